// File: rtl/map_tile_renderer.sv
// map_tile_renderer: colours one maze-tile pixel (walls, corners, dots, power pellets) per cycle.
// Latency: 2 cycles from pix_valid to out_valid; throughput one pixel per cycle.
// Backpressure: none; every accepted pixel emerges exactly two cycles later.
module map_tile_renderer #(
  parameter int TILE_W       = 8,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 16,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic [$clog2(TILE_W)-1:0] sx,
  input  logic [$clog2(TILE_W)-1:0] sy,
  input  logic [3:0]                sprite_code,
  input  logic                      frame_tick,
  input  logic                      flash_en,
  output logic [COLOR_W-1:0]        R,
  output logic [COLOR_W-1:0]        G,
  output logic [COLOR_W-1:0]        B,
  output logic                      out_valid
);

  localparam int SW = $clog2(TILE_W);
  localparam int C  = TILE_W / 2;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  // Tile geometry is centred on C; these are the only coordinates the shapes need.
  localparam logic [SW-1:0] CM2 = SW'(C - 2);
  localparam logic [SW-1:0] CM1 = SW'(C - 1);
  localparam logic [SW-1:0] C0  = SW'(C);
  localparam logic [SW-1:0] CP1 = SW'(C + 1);
  localparam logic [SW-1:0] CP2 = SW'(C + 2);
  localparam logic [SW-1:0] ONE = SW'(1);
  localparam logic [SW-1:0] TM2 = SW'(TILE_W - 2);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [COLOR_W-1:0] CMAX  = {COLOR_W{1'b1}};

  typedef enum logic [1:0] {COL_BLACK, COL_BLUE, COL_WHITE, COL_GREEN} colour_t;

  logic          s1_vld;
  logic [SW-1:0] s1_sx;
  logic [SW-1:0] s1_sy;
  logic [3:0]    s1_code;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [FW-1:0] flash_cnt;
  logic          flash_phase;

  logic    wall;
  logic    dot;
  logic    pellet;
  colour_t colour;

  assign dot = ((s1_sx == CM1) || (s1_sx == C0)) && ((s1_sy == CM1) || (s1_sy == C0));

  assign pellet = ((s1_sx >= CM2) && (s1_sx <= CP1)) ||
                  ((s1_sy >= CM2) && (s1_sy <= CP1)) ||
                  ((s1_sx >= ONE) && (s1_sx <= TM2) && ((s1_sy == ONE) || (s1_sy == TM2)));

  // Stage 1: capture the incoming pixel; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sx   <= '0;
      s1_sy   <= '0;
      s1_code <= '0;
    end else begin
      s1_vld  <= pix_valid;
      s1_sx   <= sx;
      s1_sy   <= sy;
      s1_code <= sprite_code;
    end
  end

  // Wall/corner shape test for codes 0-7 (code 8 shares the index but is never a wall).
  always_comb begin
    wall = 1'b0;
    case (s1_code[2:0])
      3'd1: wall = (s1_sy == CP1);
      3'd2: wall = (s1_sx == CM1);
      3'd3: wall = (s1_sy == CM1);
      3'd4: wall = (s1_sx == CP1);
      3'd5: wall = ((s1_sy == CP1) && (s1_sx > CP2)) || ((s1_sy > CP1) && (s1_sx == CP1)) ||
                   ((s1_sy == CP2) && (s1_sx == CP2));
      3'd6: wall = ((s1_sy == CP1) && (s1_sx < CM2)) || ((s1_sy > CP2) && (s1_sx == CM1)) ||
                   ((s1_sy == CP2) && (s1_sx == CM2));
      3'd7: wall = ((s1_sy == CM1) && (s1_sx < CM2)) || ((s1_sy < CM2) && (s1_sx == CM1)) ||
                   ((s1_sy == CM2) && (s1_sx == CM2));
      default: wall = ((s1_sy == CM1) && (s1_sx > CP2)) || ((s1_sy < CM2) && (s1_sx == CP1)) ||
                      ((s1_sy == CM2) && (s1_sx == CP2));
    endcase
  end

  // Pick the pixel colour; phases are read before this edge's counter update.
  always_comb begin
    colour = COL_BLACK;
    if (!s1_code[3]) begin
      if (wall) colour = flash_phase ? COL_WHITE : COL_BLUE;
    end else if (s1_code == 4'd9) begin
      if (dot) colour = COL_GREEN;
    end else if (s1_code == 4'd10) begin
      if (pellet && !blink_phase) colour = COL_BLUE;
    end
  end

  // Stage 2: register the colour; bubbles emerge as black with out_valid low.
  always_ff @(posedge clk) begin
    if (rst || !s1_vld) begin
      R         <= '0;
      G         <= '0;
      B         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      R         <= (colour == COL_WHITE) ? CMAX : '0;
      G         <= ((colour == COL_WHITE) || (colour == COL_GREEN)) ? CMAX : '0;
      B         <= ((colour == COL_WHITE) || (colour == COL_BLUE)) ? CMAX : '0;
    end
  end

  // Pellet blink: toggle phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Wall flash: only runs while flash_en is high, otherwise parked on blue.
  always_ff @(posedge clk) begin
    if (rst || !flash_en) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_tick) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_map_tile_renderer.sv
// tb_map_tile_renderer: exercises 8-pixel and 16-pixel tile renderers side by side.
// Latency: outputs compared one cycle after each driven step against a two-deep expectation.
// Backpressure: none in the design; stimulus is driven every cycle.
module tb_map_tile_renderer;

  localparam int CW    = 4;
  localparam int BLINK = 16;
  localparam int FLASH = 8;
  localparam logic [3*CW-1:0] BLACK = 12'h000;
  localparam logic [3*CW-1:0] BLUE  = 12'h00F;
  localparam logic [3*CW-1:0] WHITE = 12'hFFF;
  localparam logic [3*CW-1:0] GREEN = 12'h0F0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          frame_tick = 1'b0;
  logic          flash_en = 1'b0;
  logic [3:0]    sprite_code = '0;
  logic [2:0]    sx8 = '0, sy8 = '0;
  logic [3:0]    sx16 = '0, sy16 = '0;
  logic [CW-1:0] r8, g8, b8, r16, g16, b16;
  logic          ov8, ov16;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: total ticks seen, not wrapped counters
  int nblink = 0;
  int nflash = 0;
  logic            fe_lvl = 1'b0;
  logic            prev_v = 1'b0;
  logic [3*CW-1:0] prev8 = '0, prev16 = '0;
  logic            exp_v = 1'b0;
  logic [3*CW-1:0] exp8 = '0, exp16 = '0;

  map_tile_renderer #(.TILE_W(8), .COLOR_W(CW), .BLINK_FRAMES(BLINK), .FLASH_FRAMES(FLASH)) dut8 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sx(sx8), .sy(sy8), .sprite_code(sprite_code),
    .frame_tick(frame_tick), .flash_en(flash_en), .R(r8), .G(g8), .B(b8), .out_valid(ov8));

  map_tile_renderer #(.TILE_W(16), .COLOR_W(CW), .BLINK_FRAMES(BLINK), .FLASH_FRAMES(FLASH)) dut16 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sx(sx16), .sy(sy16), .sprite_code(sprite_code),
    .frame_tick(frame_tick), .flash_en(flash_en), .R(r16), .G(g16), .B(b16), .out_valid(ov16));

  always #5 clk = ~clk;

  function automatic logic [3*CW-1:0] ref_rgb(input int tw, input int code, input int x, input int y,
                                               input bit bph, input bit fph);
    int c;
    bit hit;
    c   = tw / 2;
    hit = 1'b0;
    case (code)
      1: hit = (y == c + 1);
      2: hit = (x == c - 1);
      3: hit = (y == c - 1);
      4: hit = (x == c + 1);
      5: hit = (y == c + 1 && x > c + 2) || (y > c + 1 && x == c + 1) || (y == c + 2 && x == c + 2);
      6: hit = (y == c + 1 && x < c - 2) || (y > c + 2 && x == c - 1) || (y == c + 2 && x == c - 2);
      7: hit = (y == c - 1 && x < c - 2) || (y < c - 2 && x == c - 1) || (y == c - 2 && x == c - 2);
      0: hit = (y == c - 1 && x > c + 2) || (y < c - 2 && x == c + 1) || (y == c - 2 && x == c + 2);
      default: hit = 1'b0;
    endcase
    if (code < 8) return hit ? (fph ? WHITE : BLUE) : BLACK;
    if (code == 9) return ((x == c - 1 || x == c) && (y == c - 1 || y == c)) ? GREEN : BLACK;
    if (code == 10)
      return (!bph && ((x >= c - 2 && x <= c + 1) || (y >= c - 2 && y <= c + 1) ||
                       (x >= 1 && x <= tw - 2 && (y == 1 || y == tw - 2)))) ? BLUE : BLACK;
    return BLACK;
  endfunction

  // Drive one cycle of inputs, advance the model, and leave exp_* describing the outputs after the edge.
  task automatic step(input logic v, input int code, input int x8, input int y8, input int x16,
                      input int y16, input logic tk, input logic fe, input logic rs);
    logic            new_v;
    logic [3*CW-1:0] new8, new16;
    bit              bph, fph;
    pix_valid   = v;
    sprite_code = 4'(code);
    sx8 = 3'(x8);  sy8 = 3'(y8);
    sx16 = 4'(x16); sy16 = 4'(y16);
    frame_tick = tk;
    flash_en   = fe;
    rst        = rs;
    if (rs) begin
      nblink = 0;
      nflash = 0;
    end else begin
      nblink += int'(tk);
      if (!fe) nflash = 0;
      else     nflash += int'(tk);
    end
    bph   = ((nblink / BLINK) % 2) == 1;
    fph   = ((nflash / FLASH) % 2) == 1;
    new_v = v && !rs;
    new8  = ref_rgb(8, code, x8, y8, bph, fph);
    new16 = ref_rgb(16, code, x16, y16, bph, fph);
    @(posedge clk);
    #1;
    if (rs) begin
      exp_v  = 1'b0; exp8 = BLACK; exp16 = BLACK;
      prev_v = 1'b0;
    end else begin
      exp_v  = prev_v;
      exp8   = prev_v ? prev8 : BLACK;
      exp16  = prev_v ? prev16 : BLACK;
      prev_v = new_v;
    end
    prev8  = new8;
    prev16 = new16;
  endtask

  task automatic pix(input int code, input int x, input int y);
    step(1'b1, code, x, y, x, y, 1'b0, fe_lvl, 1'b0);
  endtask

  task automatic idle(input logic tk);
    step(1'b0, 0, 0, 0, 0, 0, tk, fe_lvl, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b1, 1, 0, 5, 0, 5, 1'b1, 1'b1, 1'b1);
    step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b0, BLACK} || {ov16, r16, g16, b16} !== {1'b0, BLACK})
      $display("FAIL reset_out: got v=%0b rgb=%h / v=%0b rgb=%h want v=0 rgb=000", ov8, {r8, g8, b8}, ov16, {r16, g16, b16});
    else n_pass++;
    n_checks++;
    if (dut8.blink_cnt !== '0 || dut8.blink_phase !== 1'b0 || dut8.flash_cnt !== '0 || dut8.flash_phase !== 1'b0)
      $display("FAIL reset_cnt: got blink=%0d/%0b flash=%0d/%0b want 0/0 0/0",
               dut8.blink_cnt, dut8.blink_phase, dut8.flash_cnt, dut8.flash_phase);
    else n_pass++;
  endtask

  task automatic test_walls;
    fe_lvl = 1'b0;
    pix(1, 0, 5);
    n_checks++;
    if (ov8 !== 1'b0) $display("FAIL wall_lat1: got v=%0b want v=0", ov8);
    else n_pass++;
    pix(1, 0, 4);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLUE}) $display("FAIL wall_up: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, BLUE);
    else n_pass++;
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLACK}) $display("FAIL wall_off: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, BLACK);
    else n_pass++;
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b0, BLACK}) $display("FAIL wall_drain: got v=%0b rgb=%h want v=0 rgb=000", ov8, {r8, g8, b8});
    else n_pass++;
  endtask

  task automatic test_dots;
    pix(9, 3, 4);
    pix(9, 5, 4);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, GREEN}) $display("FAIL dot_on: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, GREEN);
    else n_pass++;
    pix(12, $urandom_range(0, 7), $urandom_range(0, 7));
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLACK}) $display("FAIL dot_off: got v=%0b rgb=%h want v=1 rgb=000", ov8, {r8, g8, b8});
    else n_pass++;
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLACK}) $display("FAIL code12: got v=%0b rgb=%h want v=1 rgb=000", ov8, {r8, g8, b8});
    else n_pass++;
  endtask

  task automatic test_pellet;
    step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    pix(10, 2, 0);
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLUE}) $display("FAIL pellet_t0: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, BLUE);
    else n_pass++;
    for (int i = 0; i < 16; i++) idle(1'b1);
    pix(10, 2, 0);
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLACK}) $display("FAIL pellet_t16: got v=%0b rgb=%h want v=1 rgb=000", ov8, {r8, g8, b8});
    else n_pass++;
    for (int i = 0; i < 16; i++) idle(1'b1);
    pix(10, 2, 0);
    pix(10, 0, 0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLUE}) $display("FAIL pellet_t32: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, BLUE);
    else n_pass++;
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLACK}) $display("FAIL pellet_corner: got v=%0b rgb=%h want v=1 rgb=000", ov8, {r8, g8, b8});
    else n_pass++;
  endtask

  task automatic test_flash;
    fe_lvl = 1'b0;
    idle(1'b0);
    fe_lvl = 1'b1;
    pix(5, 5, 7);
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLUE}) $display("FAIL flash_t0: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, BLUE);
    else n_pass++;
    for (int i = 0; i < 8; i++) idle(1'b1);
    pix(5, 5, 7);
    fe_lvl = 1'b0;
    pix(5, 5, 7);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, WHITE}) $display("FAIL flash_t8: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, WHITE);
    else n_pass++;
    idle(1'b0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, BLUE}) $display("FAIL flash_drop: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, BLUE);
    else n_pass++;
  endtask

  task automatic test_tile16;
    fe_lvl = 1'b0;
    step(1'b1, 3, 0, 0, $urandom_range(0, 15), 7, 1'b0, fe_lvl, 1'b0);
    step(1'b1, 6, 0, 0, 6, 10, 1'b0, fe_lvl, 1'b0);
    n_checks++;
    if ({ov16, r16, g16, b16} !== {1'b1, BLUE}) $display("FAIL t16_lower: got v=%0b rgb=%h want v=1 rgb=%h", ov16, {r16, g16, b16}, BLUE);
    else n_pass++;
    idle(1'b0);
    n_checks++;
    if ({ov16, r16, g16, b16} !== {1'b1, BLUE}) $display("FAIL t16_ur: got v=%0b rgb=%h want v=1 rgb=%h", ov16, {r16, g16, b16}, BLUE);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    fe_lvl = 1'b1;
    for (int i = 0; i < 6; i++)
      step(1'b1, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, fe_lvl, 1'b0);
    step(1'b1, 9, 3, 3, 8, 8, 1'b1, fe_lvl, 1'b1);
    n_checks++;
    if ({ov8, r8, g8, b8, ov16, r16, g16, b16} !== {1'b0, BLACK, 1'b0, BLACK})
      $display("FAIL rstmid_c1: got v=%0b rgb=%h / v=%0b rgb=%h want v=0 rgb=000", ov8, {r8, g8, b8}, ov16, {r16, g16, b16});
    else n_pass++;
    n_checks++;
    if (dut8.blink_cnt !== '0 || dut8.blink_phase !== 1'b0 || dut8.flash_cnt !== '0 || dut8.flash_phase !== 1'b0)
      $display("FAIL rstmid_cnt: got blink=%0d/%0b flash=%0d/%0b want 0/0 0/0",
               dut8.blink_cnt, dut8.blink_phase, dut8.flash_cnt, dut8.flash_phase);
    else n_pass++;
    pix(9, 3, 3);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b0, BLACK}) $display("FAIL rstmid_c2: got v=%0b rgb=%h want v=0 rgb=000", ov8, {r8, g8, b8});
    else n_pass++;
    pix(1, 0, 0);
    n_checks++;
    if ({ov8, r8, g8, b8} !== {1'b1, GREEN}) $display("FAIL rstmid_c3: got v=%0b rgb=%h want v=1 rgb=%h", ov8, {r8, g8, b8}, GREEN);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) fe_lvl = ~fe_lvl;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1) == 1, fe_lvl,
           $urandom_range(0, 149) == 0);
      n_checks++;
      if ({ov8, r8, g8, b8} !== {exp_v, exp8})
        $display("FAIL rand8 #%0d: got v=%0b rgb=%h want v=%0b rgb=%h", i, ov8, {r8, g8, b8}, exp_v, exp8);
      else n_pass++;
      n_checks++;
      if ({ov16, r16, g16, b16} !== {exp_v, exp16})
        $display("FAIL rand16 #%0d: got v=%0b rgb=%h want v=%0b rgb=%h", i, ov16, {r16, g16, b16}, exp_v, exp16);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_walls;
    test_dots;
    test_pellet;
    test_flash;
    test_tile16;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/map_tile_renderer.md
MAP_TILE_RENDERER -- requirements
Module: map_tile_renderer

Interface
REQ-001 SHALL have parameter TILE_W, default 8, meaning tile edge in pixels; power of 2, >= 8.
REQ-002 SHALL have parameter COLOR_W, default 4, meaning bits per colour channel.
REQ-003 SHALL have parameter BLINK_FRAMES, default 16, meaning frames per power-pellet blink half-period; >= 1.
REQ-004 SHALL have parameter FLASH_FRAMES, default 8, meaning frames per wall-flash half-period; >= 1.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-007 SHALL have port pix_valid, input, 1 bit, meaning sx/sy/sprite_code are valid this cycle.
REQ-008 SHALL have port sx, input, $clog2(TILE_W) bits, meaning pixel column within tile.
REQ-009 SHALL have port sy, input, $clog2(TILE_W) bits, meaning pixel row within tile.
REQ-010 SHALL have port sprite_code, input, 4 bits, meaning tile type.
REQ-011 SHALL have port frame_tick, input, 1 bit, meaning one-cycle pulse per video frame.
REQ-012 SHALL have port flash_en, input, 1 bit, meaning level-clear wall flashing enabled.
REQ-013 SHALL have ports R, G, B, output, COLOR_W bits each, meaning registered pixel colour.
REQ-014 SHALL have port out_valid, output, 1 bit, meaning R/G/B correspond to a pixel accepted 2 cycles earlier.

Function
REQ-015 SHALL define C = TILE_W/2; all geometry below uses C; no backpressure.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers pix_valid, sx, sy, sprite_code; stage 2 computes colour and registers R/G/B/out_valid; latency exactly 2 cycles, throughput 1 pixel/cycle.
REQ-017 SHALL, when stage-1 valid is 0, register R=G=B=0 and out_valid=0.
REQ-018 SHALL classify wall pixels per code: 1 upper, sy==C+1; 2 right, sx==C-1; 3 lower, sy==C-1; 4 left, sx==C+1.
REQ-019 SHALL classify corner pixels: 5 UL, (sy==C+1 & sx>C+2) | (sy>C+1 & sx==C+1) | (sy==C+2 & sx==C+2); 6 UR, (sy==C+1 & sx<C-2) | (sy>C+2 & sx==C-1) | (sy==C+2 & sx==C-2).
REQ-020 SHALL classify corner pixels: 7 LR, (sy==C-1 & sx<C-2) | (sy<C-2 & sx==C-1) | (sy==C-2 & sx==C-2); 0 LL, (sy==C-1 & sx>C+2) | (sy<C-2 & sx==C+1) | (sy==C-2 & sx==C+2).
REQ-021 SHALL colour wall/corner pixels blue (0,0,max) when flash_phase=0 and white (max,max,max) when flash_phase=1; non-wall pixels of codes 0-7 black.
REQ-022 SHALL render code 9 (dot) green (0,max,0) where sx,sy both in {C-1,C}, else black.
REQ-023 SHALL render code 10 (power pellet) blue where (C-2<=sx<=C+1) | (C-2<=sy<=C+1) | (1<=sx<=TILE_W-2 & (sy==1 | sy==TILE_W-2)), only when blink_phase=0; black otherwise.
REQ-024 SHALL render codes 8 and 11-15 black; every channel driven for every code.
REQ-025 SHALL keep blink_cnt ($clog2(BLINK_FRAMES+1) bits): on frame_tick, blink_cnt==BLINK_FRAMES-1 wraps to 0 and toggles blink_phase, else increments.
REQ-026 SHALL keep flash_cnt and flash_phase likewise with FLASH_FRAMES, advancing only on frame_tick while flash_en=1.
REQ-027 SHALL, while flash_en=0, hold flash_cnt=0 and flash_phase=0 (walls blue), taking effect on the next clock edge.
REQ-028 SHALL, on simultaneous frame_tick and stage-2 valid pixel, colour the pixel with pre-update phase values; the new phase applies from the next cycle.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear both pipeline stages, R=G=B=0, out_valid=0, blink_cnt=0, blink_phase=0, flash_cnt=0, flash_phase=0.
REQ-030 SHALL, on rst asserted mid-stream, discard in-flight pixels; out_valid is 0 in the cycle after reset and not 1 again until 2 cycles after first pix_valid following deassertion.
REQ-031 SHALL give rst priority over frame_tick and pix_valid in the same cycle.

Verification
REQ-032 SHALL verify: TILE_W=8, code 1, sy=5, sx=0, pix_valid pulse at cycle N -> out_valid=1, (R,G,B)=(0,0,F) at cycle N+2; sy=4 -> (0,0,0).
REQ-033 SHALL verify: code 9, sx=3,sy=4 -> (0,F,0); sx=5,sy=4 -> (0,0,0); code 12 any pixel -> (0,0,0).
REQ-034 SHALL verify: BLINK_FRAMES=16, code 10, sx=2,sy=0; after 16 frame_ticks pellet pixel black, after 32 blue again; sx=0,sy=0 always black.
REQ-035 SHALL verify: flash_en=1, FLASH_FRAMES=8, code 5, sx=5,sy=7; 8 ticks -> (F,F,F); drop flash_en -> (0,0,F) from next cycle onward.
REQ-036 SHALL verify: continuous back-to-back pixels with rst pulsed one cycle mid-stream -> out_valid=0, RGB=0 for 2 cycles, no pre-reset pixel emerges, counters at 0.
REQ-037 SHALL verify: TILE_W=16 (C=8), code 3, sy=7 -> blue; code 6, sx=6,sy=10 -> blue.
